// File: rtl/i2c_pkg.sv
// Shared definitions for the FND I2C write master: bus defaults, retry limit
// and the transmitter state encoding.
package i2c_pkg;

    localparam logic [6:0] I2C_FND_ADDR  = 7'b1100101;
    localparam int         I2C_BIT_CLKS  = 1000;
    localparam int         I2C_MAX_RETRY = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_ADDR     = 3'd2,
        ST_ADDR_ACK = 3'd3,
        ST_DATA     = 3'd4,
        ST_DATA_ACK = 3'd5,
        ST_STOP     = 3'd6,
        ST_WAIT     = 3'd7
    } i2c_master_state_t;

endpackage

// File: rtl/i2c_slot_timer.sv
// Bit-slot counter (0..BIT_CLKS-1). slot_end/sample decode the current count;
// slot_start/q1/q3 decode the count the slot will hold on the next cycle.
module i2c_slot_timer #(
    parameter int BIT_CLKS = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_slot_end,
    output logic o_sample,
    output logic o_slot_start,
    output logic o_q1,
    output logic o_q3
);

    localparam int            CW     = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] LAST   = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] SAMPLE = CW'(BIT_CLKS / 2 - 1);
    localparam logic [CW-1:0] Q1     = CW'(BIT_CLKS / 4);
    localparam logic [CW-1:0] Q3     = CW'((3 * BIT_CLKS) / 4);
    localparam logic [CW-1:0] ZERO   = CW'(1'b0);
    localparam logic [CW-1:0] ONE    = CW'(1'b1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    // next count: cleared, wrapped at slot end, or advanced
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = ZERO;
        end else if (i_en) begin
            if (r_cnt == LAST) begin
                w_cnt_nxt = ZERO;
            end else begin
                w_cnt_nxt = r_cnt + ONE;
            end
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    assign o_slot_end   = (r_cnt == LAST);
    assign o_sample     = (r_cnt == SAMPLE);
    assign o_slot_start = (w_cnt_nxt == ZERO);
    assign o_q1         = (w_cnt_nxt == Q1);
    assign o_q3         = (w_cnt_nxt == Q3);

    // slot counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= ZERO;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/i2c_fnd_master_tx.sv
// Write-only I2C master sending a 16-bit FND word in fixed-length bit slots.
// Optional address-NACK retry is enabled by defining I2C_MASTER_RETRY_EN.
module i2c_fnd_master_tx
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDRESS    = I2C_FND_ADDR,
    parameter int         BYTE_COUNT = 2,
    parameter int         BIT_CLKS   = I2C_BIT_CLKS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] tx_data,
    output logic        busy,
    output logic        done,
    output logic        ack_error,
    output logic        SCL,
    inout  wire         SDA
);

    localparam logic [7:0] ADDR_BYTE = {ADDRESS, 1'b0};
    localparam logic       LAST_BYTE = 1'(BYTE_COUNT - 1);

    i2c_master_state_t r_state, w_state_nxt;
    logic [2:0]  r_bit, w_bit_nxt;
    logic        r_byte, w_byte_nxt;
    logic [15:0] r_data, w_data_nxt;
    logic        r_ack_error, w_ack_error_nxt;
    logic        r_done, w_done_nxt;
    logic        r_nack, w_nack_nxt;
    logic        r_scl, w_scl_nxt;
    logic        r_sda_low, w_sda_low_nxt;
    logic        r_busy;
    logic        r_sda_meta, r_sda_sync;
`ifdef I2C_MASTER_RETRY_EN
    logic [1:0]  r_attempt, w_attempt_nxt;
    logic        r_retry, w_retry_nxt;
`endif

    logic w_slot_end, w_sample, w_slot_start, w_q1, w_q3;

    i2c_slot_timer #(.BIT_CLKS(BIT_CLKS)) u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_en         (r_state != ST_IDLE),
        .i_clr        (r_state == ST_IDLE),
        .o_slot_end   (w_slot_end),
        .o_sample     (w_sample),
        .o_slot_start (w_slot_start),
        .o_q1         (w_q1),
        .o_q3         (w_q3)
    );

    function automatic logic tx_bit(input i2c_master_state_t st, input logic [15:0] data,
                                    input logic byte_sel, input logic [2:0] bit_idx);
        logic [7:0] v_byte;
        if (st == ST_ADDR) begin
            v_byte = ADDR_BYTE;
        end else if (byte_sel) begin
            v_byte = data[7:0];
        end else begin
            v_byte = data[15:8];
        end
        return v_byte[~bit_idx];
    endfunction

    // transaction sequencing; decisions are taken at slot end
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_nxt       = r_bit;
        w_byte_nxt      = r_byte;
        w_data_nxt      = r_data;
        w_ack_error_nxt = r_ack_error;
        w_done_nxt      = 1'b0;
`ifdef I2C_MASTER_RETRY_EN
        w_attempt_nxt   = r_attempt;
        w_retry_nxt     = r_retry;
`endif
        if (w_sample && (r_state == ST_ADDR_ACK || r_state == ST_DATA_ACK)) begin
            w_nack_nxt = r_sda_sync;
        end else begin
            w_nack_nxt = r_nack;
        end
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt     = ST_START;
                    w_data_nxt      = tx_data;
                    w_ack_error_nxt = 1'b0;
`ifdef I2C_MASTER_RETRY_EN
                    w_attempt_nxt   = 2'd0;
                    w_retry_nxt     = 1'b0;
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_slot_end) begin
                    w_state_nxt = ST_ADDR;
                    w_bit_nxt   = 3'd0;
                end else begin
                    w_state_nxt = ST_START;
                end
            end
            ST_ADDR, ST_DATA: begin
                if (w_slot_end && r_bit == 3'd7) begin
                    w_state_nxt = (r_state == ST_ADDR) ? ST_ADDR_ACK : ST_DATA_ACK;
                end else if (w_slot_end) begin
                    w_bit_nxt = r_bit + 3'd1;
                end else begin
                    w_bit_nxt = r_bit;
                end
            end
            ST_ADDR_ACK: begin
                if (w_slot_end && !r_nack) begin
                    w_state_nxt = ST_DATA;
                    w_byte_nxt  = 1'b0;
                    w_bit_nxt   = 3'd0;
                end else if (w_slot_end) begin
                    w_state_nxt = ST_STOP;
`ifdef I2C_MASTER_RETRY_EN
                    if (r_attempt == 2'(I2C_MAX_RETRY - 1)) begin
                        w_ack_error_nxt = 1'b1;
                    end else begin
                        w_retry_nxt = 1'b1;
                    end
`else
                    w_ack_error_nxt = 1'b1;
`endif
                end else begin
                    w_state_nxt = ST_ADDR_ACK;
                end
            end
            ST_DATA_ACK: begin
                // the slave NACKs the final byte on purpose, so it never flags an error
                if (w_slot_end && r_byte == LAST_BYTE) begin
                    w_state_nxt = ST_STOP;
                end else if (w_slot_end && r_nack) begin
                    w_state_nxt     = ST_STOP;
                    w_ack_error_nxt = 1'b1;
                end else if (w_slot_end) begin
                    w_state_nxt = ST_DATA;
                    w_byte_nxt  = r_byte + 1'b1;
                    w_bit_nxt   = 3'd0;
                end else begin
                    w_state_nxt = ST_DATA_ACK;
                end
            end
            ST_STOP: begin
                if (w_slot_end) begin
`ifdef I2C_MASTER_RETRY_EN
                    if (r_retry) begin
                        w_state_nxt = ST_WAIT;
                        w_bit_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
`else
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
`endif
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_WAIT: begin
`ifdef I2C_MASTER_RETRY_EN
                if (w_slot_end && r_bit == 3'd3) begin
                    w_state_nxt   = ST_START;
                    w_retry_nxt   = 1'b0;
                    w_attempt_nxt = r_attempt + 2'd1;
                end else if (w_slot_end) begin
                    w_bit_nxt = r_bit + 3'd1;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
`else
                w_state_nxt = ST_IDLE;
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // bus line values for the coming cycle, so SCL/SDA leave a flop already aligned to the slot
    always_comb begin
        w_scl_nxt     = 1'b1;
        w_sda_low_nxt = 1'b0;
        case (w_state_nxt)
            ST_START: begin
                w_scl_nxt     = 1'b1;
                w_sda_low_nxt = 1'b1;
            end
            ST_ADDR, ST_DATA, ST_ADDR_ACK, ST_DATA_ACK: begin
                if (w_slot_start) begin
                    w_scl_nxt = 1'b0;
                end else if (w_q1) begin
                    w_scl_nxt = 1'b1;
                end else if (w_q3) begin
                    w_scl_nxt = 1'b0;
                end else begin
                    w_scl_nxt = r_scl;
                end
                if (w_state_nxt == ST_ADDR_ACK || w_state_nxt == ST_DATA_ACK) begin
                    w_sda_low_nxt = 1'b0;
                end else if (w_slot_start) begin
                    w_sda_low_nxt = ~tx_bit(w_state_nxt, w_data_nxt, w_byte_nxt, w_bit_nxt);
                end else begin
                    w_sda_low_nxt = r_sda_low;
                end
            end
            ST_STOP: begin
                if (w_slot_start) begin
                    w_scl_nxt = 1'b0;
                end else if (w_q1) begin
                    w_scl_nxt = 1'b1;
                end else begin
                    w_scl_nxt = r_scl;
                end
                if (w_slot_start) begin
                    w_sda_low_nxt = 1'b1;
                end else if (w_q3) begin
                    w_sda_low_nxt = 1'b0;
                end else begin
                    w_sda_low_nxt = r_sda_low;
                end
            end
            default: begin
                w_scl_nxt     = 1'b1;
                w_sda_low_nxt = 1'b0;
            end
        endcase
    end

    // state, datapath and output registers; reset releases the bus at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bit       <= 3'd0;
            r_byte      <= 1'b0;
            r_data      <= 16'h0000;
            r_ack_error <= 1'b0;
            r_done      <= 1'b0;
            r_nack      <= 1'b0;
            r_scl       <= 1'b1;
            r_sda_low   <= 1'b0;
            r_busy      <= 1'b0;
            r_sda_meta  <= 1'b1;
            r_sda_sync  <= 1'b1;
`ifdef I2C_MASTER_RETRY_EN
            r_attempt   <= 2'd0;
            r_retry     <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_bit       <= w_bit_nxt;
            r_byte      <= w_byte_nxt;
            r_data      <= w_data_nxt;
            r_ack_error <= w_ack_error_nxt;
            r_done      <= w_done_nxt;
            r_nack      <= w_nack_nxt;
            r_scl       <= w_scl_nxt;
            r_sda_low   <= w_sda_low_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_sda_meta  <= SDA;
            r_sda_sync  <= r_sda_meta;
`ifdef I2C_MASTER_RETRY_EN
            r_attempt   <= w_attempt_nxt;
            r_retry     <= w_retry_nxt;
`endif
        end
    end

    assign SDA       = r_sda_low ? 1'b0 : 1'bz;
    assign SCL       = r_scl;
    assign busy      = r_busy;
    assign done      = r_done;
    assign ack_error = r_ack_error;

endmodule
